// File: rtl/fir_filter.sv
// 11-tap FIR accelerator: AXI4-Lite config, AXI4-Stream in/out, external tap and data BRAMs.
// A single time-shared multiplier walks a circular sample buffer once per input sample.
module fir_filter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  output logic                   awready,
  output logic                   wready,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arready,
  input  logic                   rready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do,
  input  logic                   axis_clk,
  input  logic                   axis_rst_n
);

  localparam int CW   = $clog2(Tape_Num + 1);
  localparam int PadW = pADDR_WIDTH - CW - 2;
  localparam logic [CW-1:0] One     = CW'(1);
  localparam logic [CW-1:0] NumTaps = CW'(Tape_Num);
  localparam logic [CW-1:0] LastTap = CW'(Tape_Num - 1);
  localparam logic [pADDR_WIDTH-1:0] AddrCtrl = '0;
  localparam logic [pADDR_WIDTH-1:0] AddrLen  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] AddrTap0 = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] AddrTapN = pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StMac   = 3'd3;
  localparam logic [2:0] StOut   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [1:0] RdIdle  = 2'd0;
  localparam logic [1:0] RdAcc   = 2'd1;
  localparam logic [1:0] RdTap   = 2'd2;
  localparam logic [1:0] RdValid = 2'd3;

  logic [2:0]             state_q;
  logic [1:0]             rd_st_q;
  logic [CW-1:0]          cnt_q, wp_q, rd_idx_q, wp_next;
  logic [pDATA_WIDTH-1:0] acc_q, out_cnt_q, data_length_q, rdata_q, reg_rdata, prod;
  logic [pADDR_WIDTH-1:0] rd_addr_q;
  logic                   ap_idle_q, ap_done_q, ap_start_q, awready_q;
  logic                   wr_commit, wr_tap, rd_tap, is_last, unused_tlast;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CW-1:0] idx);
    return {{PadW{1'b0}}, idx, 2'b00};
  endfunction

  assign unused_tlast = ss_tlast;
  assign wr_commit = awready_q && awvalid && wvalid;
  assign wr_tap    = (awaddr >= AddrTap0) && (awaddr <= AddrTapN) && (awaddr[1:0] == 2'b00);
  assign rd_tap    = (rd_addr_q >= AddrTap0) && (rd_addr_q <= AddrTapN) &&
                     (rd_addr_q[1:0] == 2'b00);
  assign wp_next   = (wp_q == LastTap) ? '0 : wp_q + One;
  assign is_last   = (out_cnt_q == data_length_q - 32'd1);
  // Low 32 bits of the product are the same for signed and unsigned operands.
  assign prod      = tap_Do * data_Do;

  assign awready   = awready_q;
  assign wready    = awready_q;
  assign arready   = (rd_st_q == RdAcc);
  assign rvalid    = (rd_st_q == RdValid);
  assign rdata     = rdata_q;
  assign ss_tready = (state_q == StWait);
  assign sm_tvalid = (state_q == StOut);
  assign sm_tdata  = acc_q;
  assign sm_tlast  = (state_q == StOut) && is_last;

  always_comb begin
    reg_rdata = '0;
    if (rd_addr_q == AddrCtrl) begin
      reg_rdata = {{(pDATA_WIDTH-3){1'b0}}, ap_idle_q, ap_done_q, ap_start_q};
    end else if (rd_addr_q == AddrLen) begin
      reg_rdata = data_length_q;
    end
  end

  // Tap BRAM is shared: MAC reads while busy, host writes/reads only while idle.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (state_q == StMac && cnt_q < NumTaps) begin
      tap_EN = 1'b1;
      tap_A  = word_addr(cnt_q);
    end else if (wr_commit && wr_tap && ap_idle_q) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = awaddr - AddrTap0;
      tap_Di = wdata;
    end else if (rd_st_q == RdAcc && rd_tap && ap_idle_q) begin
      tap_EN = 1'b1;
      tap_A  = rd_addr_q - AddrTap0;
    end
  end

  always_comb begin
    data_EN = 1'b0;
    data_WE = 4'h0;
    data_A  = '0;
    data_Di = '0;
    if (state_q == StClear) begin
      data_EN = 1'b1;
      data_WE = 4'hF;
      data_A  = word_addr(cnt_q);
    end else if (state_q == StWait && ss_tvalid) begin
      data_EN = 1'b1;
      data_WE = 4'hF;
      data_A  = word_addr(wp_q);
      data_Di = ss_tdata;
    end else if (state_q == StMac && cnt_q < NumTaps) begin
      data_EN = 1'b1;
      data_A  = word_addr(rd_idx_q);
    end
  end

  // A read is not accepted while a write is pending, so the two never share the tap port.
  always_ff @(posedge axis_clk or posedge axis_rst_n) begin
    if (axis_rst_n) begin
      rd_st_q   <= RdIdle;
      rd_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      case (rd_st_q)
        RdIdle: begin
          if (arvalid && !(awvalid && wvalid) && !awready_q) begin
            rd_st_q   <= RdAcc;
            rd_addr_q <= araddr;
          end
        end
        RdAcc: begin
          if (rd_tap && ap_idle_q) begin
            rd_st_q <= RdTap;
          end else begin
            rdata_q <= reg_rdata;
            rd_st_q <= RdValid;
          end
        end
        RdTap: begin
          rdata_q <= tap_Do;
          rd_st_q <= RdValid;
        end
        default: if (rready) rd_st_q <= RdIdle;
      endcase
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst_n) begin
    if (axis_rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      wp_q          <= '0;
      rd_idx_q      <= '0;
      acc_q         <= '0;
      out_cnt_q     <= '0;
      data_length_q <= '0;
      ap_idle_q     <= 1'b1;
      ap_done_q     <= 1'b0;
      ap_start_q    <= 1'b0;
      awready_q     <= 1'b0;
    end else begin
      awready_q  <= !awready_q && awvalid && wvalid;
      ap_start_q <= wr_commit && (awaddr == AddrCtrl) && wdata[0] && ap_idle_q && !ap_start_q;
      if (wr_commit && (awaddr == AddrLen) && ap_idle_q) data_length_q <= wdata;
      case (state_q)
        StIdle: begin
          if (ap_start_q) begin
            ap_done_q <= (data_length_q == '0);
            ap_idle_q <= (data_length_q == '0);
            cnt_q     <= '0;
            state_q   <= (data_length_q == '0) ? StDone : StClear;
          end
        end
        StClear: begin
          if (cnt_q == LastTap) begin
            cnt_q     <= '0;
            wp_q      <= '0;
            out_cnt_q <= '0;
            state_q   <= StWait;
          end else begin
            cnt_q <= cnt_q + One;
          end
        end
        StWait: begin
          if (ss_tvalid) begin
            wp_q     <= wp_next;
            rd_idx_q <= wp_q;
            cnt_q    <= '0;
            acc_q    <= '0;
            state_q  <= StMac;
          end
        end
        StMac: begin
          // BRAM outputs lag the issued address by one cycle.
          if (cnt_q != '0) acc_q <= acc_q + prod;
          if (cnt_q == NumTaps) begin
            state_q <= StOut;
          end else begin
            cnt_q    <= cnt_q + One;
            rd_idx_q <= (rd_idx_q == '0) ? LastTap : rd_idx_q - One;
          end
        end
        StOut: begin
          if (sm_tready) begin
            out_cnt_q <= out_cnt_q + 32'd1;
            if (is_last) begin
              state_q   <= StDone;
              ap_done_q <= 1'b1;
              ap_idle_q <= 1'b1;
            end else begin
              state_q <= StWait;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter: behavioural BRAMs, AXI-Lite/stream drivers and a queue-based scoreboard
// whose monitor compares every stream output and read response against hand-computed values.
module tb_fir_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awready, wready, awvalid, wvalid, arready, rready, arvalid, rvalid;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        ss_tvalid, ss_tlast, ss_tready, sm_tready, sm_tvalid, sm_tlast;
  logic [31:0] ss_tdata, sm_tdata;
  logic [3:0]  tap_WE, data_WE;
  logic        tap_EN, data_EN;
  logic [31:0] tap_Di, tap_Do, data_Di, data_Do;
  logic [11:0] tap_A, data_A;

  always #5 clk = ~clk;

  fir_filter dut (
    .awready(awready), .wready(wready), .awvalid(awvalid), .awaddr(awaddr),
    .wvalid(wvalid), .wdata(wdata), .arready(arready), .rready(rready),
    .arvalid(arvalid), .araddr(araddr), .rvalid(rvalid), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tready(sm_tready), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A),
    .data_Do(data_Do), .axis_clk(clk), .axis_rst_n(rst)
  );

  // Single-port BRAMs, read-before-write, Do registered one cycle after A.
  logic [31:0] tap_mem [0:10];
  logic [31:0] data_mem[0:10];
  logic [9:0]  tap_idx, data_idx;
  assign tap_idx  = tap_A[11:2];
  assign data_idx = data_A[11:2];

  always @(posedge clk) begin
    if (tap_EN && tap_idx < 10'd11) begin
      tap_Do <= tap_mem[tap_idx];
      for (int b = 0; b < 4; b++) if (tap_WE[b]) tap_mem[tap_idx][8*b +: 8] <= tap_Di[8*b +: 8];
    end
    if (data_EN && data_idx < 10'd11) begin
      data_Do <= data_mem[data_idx];
      for (int b = 0; b < 4; b++)
        if (data_WE[b]) data_mem[data_idx][8*b +: 8] <= data_Di[8*b +: 8];
    end
  end

  typedef struct {logic [31:0] data; logic last;} sm_exp_t;
  typedef struct {logic [31:0] val; logic [31:0] mask;} rd_exp_t;
  sm_exp_t sm_q[$];
  rd_exp_t rd_q[$];
  sm_exp_t sm_e;
  rd_exp_t rd_e;
  int checks = 0, failures = 0, sm_pops = 0;

  int taps[11]     = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  int imp_exp[12]  = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0, 0};
  int step_exp[11] = '{0, -10, -19, 4, 60, 123, 179, 202, 193, 183, 183};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  always @(negedge clk) begin
    if (!rst && sm_tvalid && sm_tready) begin
      if (sm_q.size() == 0) begin
        fail_now("sm_unexpected_output");
      end else begin
        sm_e = sm_q.pop_front();
        check($sformatf("sm_tdata[%0d]", sm_pops), sm_tdata, sm_e.data);
        check($sformatf("sm_tlast[%0d]", sm_pops), 32'(sm_tlast), 32'(sm_e.last));
        sm_pops++;
      end
    end
    if (!rst && rvalid && rready) begin
      if (rd_q.size() == 0) begin
        fail_now("rd_unexpected_response");
      end else begin
        rd_e = rd_q.pop_front();
        check("axi_rdata", rdata & rd_e.mask, rd_e.val & rd_e.mask);
      end
    end
  end

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 100);
    if (!awready) fail_now("axi_write_awready");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] v, input logic [31:0] m);
    int n = 0;
    rd_q.push_back('{val: v, mask: m});
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 100);
    if (!arready) fail_now("axi_read_arready");
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    if (!rvalid) fail_now("axi_read_rvalid");
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // kind 0: impulse 1,0,0,...; kind 1: step of ones.
  task automatic send_stream(input int kind, input int len);
    for (int i = 0; i < len; i++) begin
      int n = 0;
      ss_tvalid = 1'b1;
      ss_tdata  = (kind == 1 || i == 0) ? 32'd1 : 32'd0;
      ss_tlast  = (i == len - 1);
      do begin @(negedge clk); n++; end while (!ss_tready && n < 500);
      if (!ss_tready) fail_now("ss_tready_wait");
      @(posedge clk); #1;
    end
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
  endtask

  task automatic start_run(input int kind, input int len);
    for (int i = 0; i < len; i++)
      sm_q.push_back('{data: 32'(kind == 0 ? imp_exp[i] : step_exp[i]), last: (i == len - 1)});
    axi_write(12'h010, 32'(len));
    axi_write(12'h000, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sm_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (sm_q.size() != 0) fail_now("sm_drain");
  endtask

  initial begin
    int base;
    int n;
    awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0;
    arvalid = 0; araddr = '0; rready = 0;
    ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; sm_tready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_ss_tready", 32'(ss_tready), 32'd0);
    check("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    check("rst_sm_tdata", sm_tdata, 32'd0);
    check("rst_bram_en", {30'd0, tap_EN, data_EN}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    axi_read(12'h000, 32'h4, 32'hFFFF_FFFF);
    axi_read(12'h010, 32'd0, 32'hFFFF_FFFF);
    axi_write(12'h010, 32'd600);
    for (int k = 0; k < 11; k++) axi_write(12'(32 + 4 * k), 32'(taps[k]));
    for (int k = 0; k < 11; k++) axi_read(12'(32 + 4 * k), 32'(taps[k]), 32'hFFFF_FFFF);
    axi_read(12'h010, 32'd600, 32'hFFFF_FFFF);
    axi_read(12'h0FC, 32'd0, 32'hFFFF_FFFF);

    // Run 1: impulse, with host traffic that must be ignored while busy.
    start_run(0, 12);
    fork
      send_stream(0, 12);
      begin
        repeat (30) @(posedge clk);
        #1;
        axi_read(12'h000, 32'd0, 32'hF);
        axi_write(12'h020, 32'd77);
        axi_read(12'h024, 32'd0, 32'hFFFF_FFFF);
        axi_write(12'h010, 32'd3);
        axi_write(12'h000, 32'd1);
      end
    join
    drain();
    repeat (3) @(posedge clk);
    axi_read(12'h000, 32'h6, 32'hFFFF_FFFF);
    axi_read(12'h000, 32'h6, 32'hFFFF_FFFF);

    // Run 2: step, with a 20-cycle sink stall in front of the fifth output.
    base = sm_pops;
    start_run(1, 11);
    fork
      send_stream(1, 11);
      begin
        n = 0;
        while (sm_pops < base + 4 && n < 2000) begin @(negedge clk); n++; end
        if (sm_pops < base + 4) fail_now("stall_wait_pops");
        @(posedge clk); #1;
        sm_tready = 1'b0;
        n = 0;
        while (!sm_tvalid && n < 200) begin @(negedge clk); n++; end
        if (!sm_tvalid) fail_now("stall_wait_valid");
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          check("stall_sm_tdata", sm_tdata, 32'(step_exp[4]));
          check("stall_sm_tvalid", 32'(sm_tvalid), 32'd1);
          check("stall_ss_tready", 32'(ss_tready), 32'd0);
        end
        @(posedge clk); #1;
        sm_tready = 1'b1;
      end
    join
    drain();
    axi_read(12'h000, 32'h6, 32'hFFFF_FFFF);

    // Run 3: impulse again; stale step samples must have been cleared, h[0] still 0.
    start_run(0, 12);
    send_stream(0, 12);
    drain();
    axi_read(12'h020, 32'd0, 32'hFFFF_FFFF);

    // Zero length: straight to done, no stream traffic.
    axi_write(12'h010, 32'd0);
    axi_write(12'h000, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("len0_sm_tvalid", 32'(sm_tvalid), 32'd0);
    axi_read(12'h000, 32'h6, 32'hFFFF_FFFF);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
